// File: rtl/nested_ifs_cfg_loader.sv
// Configuration loader for the nested_ifs atom.
// Collects a 14-word frame into shadow storage, validates its checksum and
// reserved bits, then commits every active constant/selector/opcode in one edge.

module nested_ifs_cfg_loader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i__cfg_valid,
    input  logic        i__cfg_sop,
    input  logic [31:0] i__cfg_data,
    output logic        o__cfg_ready,
    output logic [31:0] o__cons_1,
    output logic [31:0] o__cons_2,
    output logic [31:0] o__cons_3,
    output logic [31:0] o__cons_4,
    output logic [31:0] o__cons_5,
    output logic [31:0] o__cons_6,
    output logic [31:0] o__cons_7,
    output logic [31:0] o__cons_8,
    output logic [31:0] o__cons_9,
    output logic [31:0] o__cons_10,
    output logic [31:0] o__cons_11,
    output logic        o__sel_1,
    output logic [1:0]  o__sel_2,
    output logic [1:0]  o__sel_3,
    output logic        o__sel_4,
    output logic [1:0]  o__sel_5,
    output logic [1:0]  o__sel_6,
    output logic        o__sel_7,
    output logic [1:0]  o__sel_8,
    output logic [1:0]  o__sel_9,
    output logic        o__sel_10,
    output logic [1:0]  o__sel_11,
    output logic [1:0]  o__sel_12,
    output logic        o__sel_13,
    output logic [1:0]  o__sel_14,
    output logic [1:0]  o__sel_15,
    output logic        o__sel_16,
    output logic [1:0]  o__sel_17,
    output logic [1:0]  o__sel_18,
    output logic        o__sel_19,
    output logic [1:0]  o__sel_20,
    output logic [1:0]  o__sel_21,
    output logic [1:0]  o__rel_op1,
    output logic [1:0]  o__rel_op2,
    output logic [1:0]  o__rel_op3,
    output logic        o__arith_op1,
    output logic        o__arith_op2,
    output logic        o__arith_op3,
    output logic        o__arith_op4,
    output logic        o__cfg_done,
    output logic        o__cfg_err,
    output logic [7:0]  o__cfg_gen,
    output logic [7:0]  o__err_cnt
);

    typedef enum logic [1:0] {StIdle, StLoad, StCheck} state_e;

    state_e      state_q;
    logic [3:0]  idx_q;
    logic [31:0] shadow_q [0:13];
    logic [31:0] csum_q;
    logic [31:0] cons_q [0:10];
    logic [29:0] w11_q;
    logic [14:0] w12_q;
    logic        done_q;
    logic        err_q;
    logic [7:0]  gen_q;
    logic [7:0]  err_cnt_q;

    logic        accept;
    logic        frame_ok;
    logic [7:0]  err_cnt_inc;

    // Ready only drops for the single CHECK cycle.
    assign o__cfg_ready = (state_q != StCheck);
    assign accept       = i__cfg_valid && o__cfg_ready;

    // W13 must match the running XOR of W0..W12 and all reserved bits must be clear.
    assign frame_ok = (shadow_q[13] == csum_q) &&
                      (shadow_q[11][31:30] == 2'b00) &&
                      (shadow_q[12][31:15] == 17'd0);

    // Saturating error counter increment.
    assign err_cnt_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    // Frame collection FSM, commit of active registers and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            idx_q     <= 4'd0;
            csum_q    <= 32'd0;
            w11_q     <= 30'd0;
            w12_q     <= 15'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            gen_q     <= 8'd0;
            err_cnt_q <= 8'd0;
            for (int i = 0; i < 14; i++) shadow_q[i] <= 32'd0;
            for (int i = 0; i < 11; i++) cons_q[i] <= 32'd0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (i__cfg_sop) begin
                            shadow_q[0] <= i__cfg_data;
                            csum_q      <= i__cfg_data;
                            idx_q       <= 4'd1;
                            state_q     <= StLoad;
                        end else begin
                            // Stray word outside a frame: drop it.
                            err_q     <= 1'b1;
                            err_cnt_q <= err_cnt_inc;
                        end
                    end
                end
                StLoad: begin
                    if (accept) begin
                        if (i__cfg_sop) begin
                            // Abort the partial frame and restart on this word.
                            shadow_q[0] <= i__cfg_data;
                            csum_q      <= i__cfg_data;
                            idx_q       <= 4'd1;
                            err_q       <= 1'b1;
                            err_cnt_q   <= err_cnt_inc;
                        end else begin
                            shadow_q[idx_q] <= i__cfg_data;
                            idx_q           <= idx_q + 4'd1;
                            if (idx_q == 4'd13) begin
                                state_q <= StCheck;
                            end else begin
                                csum_q <= csum_q ^ i__cfg_data;
                            end
                        end
                    end
                end
                StCheck: begin
                    state_q <= StIdle;
                    if (frame_ok) begin
                        for (int i = 0; i < 11; i++) cons_q[i] <= shadow_q[i];
                        w11_q  <= shadow_q[11][29:0];
                        w12_q  <= shadow_q[12][14:0];
                        done_q <= 1'b1;
                        gen_q  <= gen_q + 8'd1;
                    end else begin
                        err_q     <= 1'b1;
                        err_cnt_q <= err_cnt_inc;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o__cons_1  = cons_q[0];
    assign o__cons_2  = cons_q[1];
    assign o__cons_3  = cons_q[2];
    assign o__cons_4  = cons_q[3];
    assign o__cons_5  = cons_q[4];
    assign o__cons_6  = cons_q[5];
    assign o__cons_7  = cons_q[6];
    assign o__cons_8  = cons_q[7];
    assign o__cons_9  = cons_q[8];
    assign o__cons_10 = cons_q[9];
    assign o__cons_11 = cons_q[10];

    assign o__sel_1  = w11_q[0];
    assign o__sel_2  = w11_q[2:1];
    assign o__sel_3  = w11_q[4:3];
    assign o__sel_4  = w11_q[5];
    assign o__sel_5  = w11_q[7:6];
    assign o__sel_6  = w11_q[9:8];
    assign o__sel_7  = w11_q[10];
    assign o__sel_8  = w11_q[12:11];
    assign o__sel_9  = w11_q[14:13];
    assign o__sel_10 = w11_q[15];
    assign o__sel_11 = w11_q[17:16];
    assign o__sel_12 = w11_q[19:18];
    assign o__sel_13 = w11_q[20];
    assign o__sel_14 = w11_q[22:21];
    assign o__sel_15 = w11_q[24:23];
    assign o__sel_16 = w11_q[25];
    assign o__sel_17 = w11_q[27:26];
    assign o__sel_18 = w11_q[29:28];

    assign o__sel_19    = w12_q[0];
    assign o__sel_20    = w12_q[2:1];
    assign o__sel_21    = w12_q[4:3];
    assign o__rel_op1   = w12_q[6:5];
    assign o__rel_op2   = w12_q[8:7];
    assign o__rel_op3   = w12_q[10:9];
    assign o__arith_op1 = w12_q[11];
    assign o__arith_op2 = w12_q[12];
    assign o__arith_op3 = w12_q[13];
    assign o__arith_op4 = w12_q[14];

    assign o__cfg_done = done_q;
    assign o__cfg_err  = err_q;
    assign o__cfg_gen  = gen_q;
    assign o__err_cnt  = err_cnt_q;

endmodule
